// File: rtl/iic_slave_resp.sv
// I2C target with a byte-wide register memory, 24Cxx EEPROM style.
// Ports: s_clk/s_rst system clock and async reset; scl/sda_in bus pads in;
// sda_oe open-drain pull-down; busy while addressed; wr_stb/wr_addr/wr_data
// report each byte committed to memory.
module iic_slave_resp #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         MEM_AW   = 8
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              scl,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_stb,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        WADR,
        WADR_ACK,
        WDAT,
        WDAT_ACK,
        RDAT,
        RACK,
        IGNORE
    } state_t;

    localparam logic [MEM_AW-1:0] PTR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    // [1:0] form the 2-flop synchroniser, [2] holds the previous synced value
    logic [2:0]        scl_s_q, scl_s_d;
    logic [2:0]        sda_s_q, sda_s_d;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_stb_q, wr_stb_d;
    logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic [7:0]        mem [2**MEM_AW];
    logic              mem_we;

    logic              scl_c, scl_p, sda_c, sda_p;
    logic              scl_rise, scl_fall;
    logic              start_det, stop_det;
    logic [7:0]        rx_byte;
    logic [MEM_AW-1:0] ptr_inc;
    logic [7:0]        rd_cur, rd_nxt;

    assign scl_s_d   = {scl_s_q[1:0], scl};
    assign sda_s_d   = {sda_s_q[1:0], sda_in};

    assign scl_c     = scl_s_q[1];
    assign scl_p     = scl_s_q[2];
    assign sda_c     = sda_s_q[1];
    assign sda_p     = sda_s_q[2];

    assign scl_rise  = scl_c & ~scl_p;
    assign scl_fall  = ~scl_c & scl_p;
    // SCL must be high on both samples so a data change racing
    // an SCL edge is never taken for a bus condition
    assign start_det = scl_c & scl_p & sda_p & ~sda_c;
    assign stop_det  = scl_c & scl_p & ~sda_p & sda_c;

    assign rx_byte   = {sr_q[6:0], sda_c};
    assign ptr_inc   = ptr_q + PTR_ONE;
    assign rd_cur    = mem[ptr_q];
    assign rd_nxt    = mem[ptr_inc];

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;

        if (start_det) begin
            state_d  = DEV;
            cnt_d    = 3'd0;
            sr_d     = 8'h00;
            ack_d    = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = 3'd0;
            ack_d    = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end

                DEV: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                rw_d    = rx_byte[0];
                                state_d = DEV_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end

                // First fall after the 8th bit starts the ACK; the
                // second fall ends it and hands over to the next phase.
                DEV_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else if (rw_q) begin
                            sr_d     = rd_cur;
                            sda_oe_d = ~rd_cur[7];
                            cnt_d    = 3'd0;
                            state_d  = RDAT;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = WADR;
                        end
                    end
                end

                WADR: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ptr_d   = rx_byte[MEM_AW-1:0];
                            state_d = WADR_ACK;
                        end
                    end
                end

                WADR_ACK, WDAT_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            state_d  = WDAT;
                        end
                    end
                end

                WDAT: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            mem_we    = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            ptr_d     = ptr_inc;
                            state_d   = WDAT_ACK;
                        end
                    end
                end

                // sr_q[7] is the bit on the bus; each fall presents the next
                RDAT: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = RACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~sr_q[6];
                        sr_d     = {sr_q[6:0], 1'b0};
                    end
                end

                // Fall releases SDA for the master's bit; the rise samples
                // it; on ACK the following fall drives the next MSB.
                RACK: begin
                    if (scl_rise) begin
                        if (sda_c) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d = ptr_inc;
                            sr_d  = rd_nxt;
                            ack_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            sda_oe_d = ~sr_q[7];
                            cnt_d    = 3'd0;
                            ack_d    = 1'b0;
                            state_d  = RDAT;
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            scl_s_q   <= 3'b111;
            sda_s_q   <= 3'b111;
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            sr_q      <= 8'h00;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            scl_s_q   <= scl_s_d;
            sda_s_q   <= sda_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge s_clk) begin
        if (mem_we) begin
            mem[ptr_q] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_iic_slave_resp.sv
// Bench for iic_slave_resp: bit-banged I2C master, EEPROM reference model,
// write-strobe scoreboard with a decoupled monitor thread.
module tb_iic_slave_resp;

    localparam int Q = 8;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl_m = 1'b1;
    logic       m_oe  = 1'b0;
    wire        sda_bus;
    logic       sda_oe, busy, wr_stb;
    logic [7:0] wr_addr, wr_data;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  model [256];
    logic [7:0]  mptr;
    logic [7:0]  wbuf [4];
    bit          oe_seen;

    always #5 clk = ~clk;

    assign sda_bus = ~(m_oe | sda_oe);

    iic_slave_resp #(.DEV_ADDR(7'h50), .MEM_AW(8)) dut (
        .s_clk   (clk),
        .s_rst   (rst),
        .scl     (scl_m),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic qd();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; qd();
        scl_m = 1'b1; qd();
        m_oe = 1'b1; qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; qd();
        scl_m = 1'b1; qd();
        m_oe = 1'b0; qd();
    endtask

    task automatic wbit(input logic b);
        m_oe = ~b; qd();
        scl_m = 1'b1; qd(); qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        m_oe = 1'b0; qd();
        scl_m = 1'b1; qd();
        ack = ~sda_bus; qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_oe = 1'b0; qd();
            scl_m = 1'b1; qd();
            d = {d[6:0], sda_bus}; qd();
            scl_m = 1'b0; qd();
        end
        wbit(nack);
    endtask

    task automatic ee_write(input logic [7:0] a, input int n);
        logic ack;
        logic [7:0] ai;
        bus_start();
        wbyte(8'hA0, ack); chk("dev_ack", {15'd0, ack}, 16'd1);
        chk("busy_hi", {15'd0, busy}, 16'd1);
        wbyte(a, ack); chk("wadr_ack", {15'd0, ack}, 16'd1);
        for (int i = 0; i < n; i++) begin
            ai = a + 8'(i);
            exp_q.push_back({ai, wbuf[i]});
            model[ai] = wbuf[i];
            wbyte(wbuf[i], ack); chk("wdat_ack", {15'd0, ack}, 16'd1);
        end
        bus_stop(); qd();
        chk("busy_lo", {15'd0, busy}, 16'd0);
        mptr = a + 8'(n);
    endtask

    task automatic ee_read(input logic [7:0] a, input int n);
        logic ack;
        logic [7:0] d, ai;
        bus_start();
        wbyte(8'hA0, ack); chk("rdev_ack", {15'd0, ack}, 16'd1);
        wbyte(a, ack); chk("radr_ack", {15'd0, ack}, 16'd1);
        bus_start();
        wbyte(8'hA1, ack); chk("rsel_ack", {15'd0, ack}, 16'd1);
        for (int i = 0; i < n; i++) begin
            ai = a + 8'(i);
            rbyte(i == n - 1, d);
            chk("rd_data", {8'd0, d}, {8'd0, model[ai]});
        end
        qd();
        chk("oe_nack", {15'd0, sda_oe}, 16'd0);
        bus_stop(); qd();
        chk("busy_rd", {15'd0, busy}, 16'd0);
        mptr = a + 8'(n - 1);
    endtask

    initial begin
        logic ack;
        logic [7:0] d, a;
        int n;

        fork
            forever begin
                @(negedge clk);
                if (sda_oe) oe_seen = 1'b1;
                if (!rst && wr_stb) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL wr_unexp: got %0h:%0h expected none",
                                 wr_addr, wr_data);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        chk("wr_addr", {8'd0, wr_addr}, {8'd0, e[15:8]});
                        chk("wr_data", {8'd0, wr_data}, {8'd0, e[7:0]});
                    end
                end
            end
        join_none

        mptr = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_oe", {15'd0, sda_oe}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_stb", {15'd0, wr_stb}, 16'd0);
        chk("rst_addr", {8'd0, wr_addr}, 16'd0);
        chk("rst_data", {8'd0, wr_data}, 16'd0);
        @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // basic write
        wbuf[0] = 8'h5A;
        ee_write(8'h10, 1);

        // wrong device address
        oe_seen = 1'b0;
        bus_start();
        wbyte(8'hA4, ack); chk("bad_ack", {15'd0, ack}, 16'd0);
        chk("bad_busy", {15'd0, busy}, 16'd0);
        wbyte(8'h10, ack); chk("bad_ack2", {15'd0, ack}, 16'd0);
        bus_stop(); qd();
        chk("bad_oe", {15'd0, oe_seen}, 16'd0);

        // random read of the byte just written
        ee_read(8'h10, 1);

        // wrap at the top of memory
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        ee_write(8'hFF, 2);
        ee_read(8'hFF, 2);

        // STOP in the middle of a data byte
        bus_start();
        wbyte(8'hA0, ack); chk("p_dev", {15'd0, ack}, 16'd1);
        wbyte(8'h30, ack); chk("p_adr", {15'd0, ack}, 16'd1);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        bus_stop(); qd();
        chk("p_busy", {15'd0, busy}, 16'd0);
        wbuf[0] = 8'h77;
        ee_write(8'h30, 1);

        // reset while driving a read bit low
        bus_start();
        wbyte(8'hA0, ack);
        wbyte(8'h10, ack);
        bus_start();
        wbyte(8'hA1, ack); chk("r6_ack", {15'd0, ack}, 16'd1);
        chk("r6_oe_hi", {15'd0, sda_oe}, {15'd0, ~model[8'h10][7]});
        rst = 1'b1;
        #1;
        chk("r6_oe_rst", {15'd0, sda_oe}, 16'd0);
        repeat (3) @(posedge clk);
        rst = 1'b0;
        mptr = 8'h00;
        repeat (4) @(posedge clk);
        bus_start();
        wbyte(8'hA1, ack); chk("r6_sel", {15'd0, ack}, 16'd1);
        rbyte(1'b1, d);
        chk("r6_ptr0", {8'd0, d}, {8'd0, model[mptr]});
        bus_stop(); qd();

        // randomized burst writes and sequential read-backs
        for (int it = 0; it < 10; it++) begin
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            ee_write(a, n);
            ee_read(a, $urandom_range(1, n));
        end

        repeat (20) @(posedge clk);
        chk("wr_q_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
